// File: rtl/lfsr_seq_checker.sv
// Health monitor for an LFSR stage: predicts each sample from the previous one, counts
// mismatches, measures the sequence period and flags the all-zero lock-up state.
module lfsr_seq_checker #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1001,
  parameter int               LOCK_MATCHES = 4,
  parameter int               CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lockup
);

  localparam int               RUN_W   = $clog2(LOCK_MATCHES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_MATCHES);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKUP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] seed, seed_d;
  logic [WIDTH-1:0] expected, expected_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [RUN_W-1:0] match_run, match_run_d;
  logic [RUN_W-1:0] run_inc;
  logic             locked_d, err_pulse_d, period_valid_d, lockup_d;
  logic [CNT_W-1:0] err_count_d, period_d;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      seed         <= '0;
      expected     <= '0;
      cnt          <= '0;
      match_run    <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lockup       <= 1'b0;
    end else begin
      state        <= state_d;
      seed         <= seed_d;
      expected     <= expected_d;
      cnt          <= cnt_d;
      match_run    <= match_run_d;
      locked       <= locked_d;
      err_pulse    <= err_pulse_d;
      err_count    <= err_count_d;
      period       <= period_d;
      period_valid <= period_valid_d;
      lockup       <= lockup_d;
    end
  end

  assign run_inc = (match_run == RUN_MAX) ? RUN_MAX : match_run + RUN_ONE;

  always_comb begin
    state_d        = state;
    seed_d         = seed;
    expected_d     = expected;
    cnt_d          = cnt;
    match_run_d    = match_run;
    locked_d       = locked;
    lockup_d       = lockup;
    err_count_d    = err_count;
    period_d       = period;
    err_pulse_d    = 1'b0;
    period_valid_d = 1'b0;

    if (in_valid) begin
      case (state)
        IDLE, LOCKUP: begin
          if (data_in == '0) begin
            state_d  = LOCKUP;
            lockup_d = 1'b1;
          end else begin
            state_d     = TRACK;
            lockup_d    = 1'b0;
            seed_d      = data_in;
            expected_d  = lfsr_next(data_in);
            cnt_d       = '0;
            match_run_d = '0;
          end
        end
        TRACK: begin
          if (data_in == expected) begin
            expected_d  = lfsr_next(data_in);
            match_run_d = run_inc;
            if (run_inc == RUN_MAX) locked_d = 1'b1;
            // A saturated count means the period overflowed; the seed hit only restarts it.
            if (data_in == seed) begin
              cnt_d = '0;
              if (cnt != CNT_MAX) begin
                period_d       = cnt + CNT_ONE;
                period_valid_d = 1'b1;
              end
            end else if (cnt != CNT_MAX) begin
              cnt_d = cnt + CNT_ONE;
            end
          end else begin
            err_pulse_d = 1'b1;
            if (err_count != CNT_MAX) err_count_d = err_count + CNT_ONE;
            locked_d    = 1'b0;
            match_run_d = '0;
            if (data_in == '0) begin
              state_d  = LOCKUP;
              lockup_d = 1'b1;
            end else begin
              seed_d     = data_in;
              expected_d = lfsr_next(data_in);
              cnt_d      = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed, table-driven bench for lfsr_seq_checker (WIDTH=4, TAPS=1001, period 15).
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] data_in = 4'b0000;
  logic       locked, err_pulse, period_valid, lockup;
  logic [7:0] err_count, period;

  int checks = 0;
  int errors = 0;

  lfsr_seq_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .period(period), .period_valid(period_valid), .lockup(lockup)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] data;
    logic       e_locked;
    logic       e_err;
    logic       e_pv;
    logic       e_lockup;
    logic [7:0] e_errc;
    logic [7:0] e_period;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];
  vec_t t3[$];
  vec_t t6[$];

  function automatic vec_t mk(logic rst, logic v, logic [3:0] d, logic lk, logic ep,
                              logic pv, logic lu, logic [7:0] ec, logic [7:0] pr);
    vec_t r;
    r.rst = rst; r.valid = v; r.data = d; r.e_locked = lk; r.e_err = ep;
    r.e_pv = pv; r.e_lockup = lu; r.e_errc = ec; r.e_period = pr;
    return r;
  endfunction

  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] d);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t e);
    logic [19:0] act, req;
    act = {locked, err_pulse, period_valid, lockup, err_count, period};
    req = {e.e_locked, e.e_err, e.e_pv, e.e_lockup, e.e_errc, e.e_period};
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual{lk,err,pv,lu,errc,per}=%b_%b_%b_%b_%0d_%0d required=%b_%b_%b_%b_%0d_%0d",
               name, locked, err_pulse, period_valid, lockup, err_count, period,
               e.e_locked, e.e_err, e.e_pv, e.e_lockup, e.e_errc, e.e_period);
    end
  endtask

  task automatic runVec(input string name, input vec_t e);
    applyStimulus(e.rst, e.valid, e.data);
    checkOutput(name, e);
  endtask

  initial begin
    logic [3:0] seq [16];
    vec_t g;
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
            4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Full period from a fresh seed of 0001.
    for (int i = 0; i < 16; i++)
      t1.push_back(mk(0, 1, seq[i], i >= 4, 0, i == 15, 0, 8'd0, (i == 15) ? 8'd15 : 8'd0));

    // Error injection on a locked stream and relock.
    for (int i = 1; i <= 8; i++) t2.push_back(mk(0, 1, seq[i], 1, 0, 0, 0, 8'd0, 8'd15));
    t2.push_back(mk(0, 1, 4'b1111, 0, 1, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b1110, 0, 0, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b1101, 0, 0, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b1010, 0, 0, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b0101, 1, 0, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b1011, 1, 0, 0, 0, 8'd1, 8'd15));
    t2.push_back(mk(0, 1, 4'b0110, 1, 0, 0, 0, 8'd1, 8'd15));

    // Zero sample while tracking, extra zeros ignored, recovery from 0001.
    t3.push_back(mk(0, 1, 4'b0000, 0, 1, 0, 1, 8'd2, 8'd15));
    for (int i = 0; i < 3; i++) t3.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 1, 8'd2, 8'd15));
    t3.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 0, 8'd2, 8'd15));
    for (int j = 1; j < 16; j++)
      t3.push_back(mk(0, 1, seq[j], j >= 4, 0, j == 15, 0, 8'd2, 8'd15));

    // Seven samples then reset with a valid sample present: reset must win.
    for (int i = 1; i <= 7; i++) t6.push_back(mk(0, 1, seq[i], 1, 0, 0, 0, 8'd2, 8'd15));
    t6.push_back(mk(1, 1, 4'b1011, 0, 0, 0, 0, 8'd0, 8'd0));

    runVec("reset", mk(1, 0, 4'b0000, 0, 0, 0, 0, 8'd0, 8'd0));
    foreach (t1[i]) runVec($sformatf("period[%0d]", i), t1[i]);
    foreach (t2[i]) runVec($sformatf("inject[%0d]", i), t2[i]);
    foreach (t3[i]) runVec($sformatf("lockup[%0d]", i), t3[i]);
    foreach (t6[i]) runVec($sformatf("midreset[%0d]", i), t6[i]);
    foreach (t1[i]) runVec($sformatf("restart[%0d]", i), t1[i]);

    // Gapped stream: garbage data on idle cycles must be ignored and pulses must drop.
    runVec("gap_reset", mk(1, 0, 4'b0000, 0, 0, 0, 0, 8'd0, 8'd0));
    foreach (t1[i]) begin
      runVec($sformatf("gap_valid[%0d]", i), t1[i]);
      for (int k = 0; k < 2; k++) begin
        g = t1[i];
        g.valid = 1'b0;
        g.data  = (k == 0) ? 4'b0000 : 4'b1111;
        g.e_err = 1'b0;
        g.e_pv  = 1'b0;
        runVec($sformatf("gap_idle[%0d.%0d]", i, k), g);
      end
    end

    // Repeating the seed is a mismatch every time; count must stop at 255.
    runVec("sat_reset", mk(1, 0, 4'b0000, 0, 0, 0, 0, 8'd0, 8'd0));
    runVec("sat_seed", mk(0, 1, 4'b0001, 0, 0, 0, 0, 8'd0, 8'd0));
    for (int k = 1; k <= 300; k++)
      runVec($sformatf("sat[%0d]", k),
             mk(0, 1, 4'b0001, 0, 1, 0, 0, (k > 255) ? 8'd255 : 8'(k), 8'd0));
    runVec("sat_idle", mk(0, 0, 4'b0001, 0, 0, 0, 0, 8'd255, 8'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
